// File: rtl/jtframe_debug_probe.sv
// On-screen debug probe: picks one of four game signals, condenses it per frame
// (live / peak / event count / sticky OR) and latches the result at vertical blank.
module jtframe_debug_probe (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] debug_bus,
  input  logic       lvbl,
  input  logic       freeze,
  input  logic [7:0] probe0,
  input  logic [7:0] probe1,
  input  logic [7:0] probe2,
  input  logic [7:0] probe3,
  input  logic [3:0] trig,
  output logic [7:0] debug_view,
  output logic       view_upd
);

  typedef enum logic [1:0] {
    MODE_LIVE  = 2'd0,
    MODE_PEAK  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_OR    = 2'd3
  } mode_e;

  logic [1:0] sel_q,       sel_d;
  mode_e      mode_q,      mode_d;
  logic [3:0] cfg_prev_q,  cfg_prev_d;
  logic [7:0] sample_q,    sample_d;
  logic       trig_q,      trig_d;
  logic       trig_prev_q, trig_prev_d;
  logic       lvbl_q,      lvbl_d;
  logic [7:0] acc_q,       acc_d;
  logic [7:0] view_q,      view_d;
  logic       upd_q,       upd_d;

  logic       cfg_chg;
  logic       fb;
  logic       trig_edge;
  logic       load;
  logic [7:0] peak_v;
  logic [7:0] cnt_v;
  logic [7:0] or_v;
  logic [7:0] acc_run;
  logic [7:0] acc_fb;
  logic [7:0] load_val;

  // upper control bits are reserved for other overlay features
  logic unused_bus;
  assign unused_bus = ^debug_bus[7:4];

  always_comb begin
    sel_d      = debug_bus[1:0];
    mode_d     = mode_e'(debug_bus[3:2]);
    cfg_prev_d = {mode_q, sel_q};
    lvbl_d     = lvbl;

    sample_d = probe0;
    case (sel_q)
      2'd0: sample_d = probe0;
      2'd1: sample_d = probe1;
      2'd2: sample_d = probe2;
      2'd3: sample_d = probe3;
      default: sample_d = probe0;
    endcase
    trig_d = trig[sel_q];

    // first clk on which the registered selection differs from the one before
    cfg_chg   = {mode_q, sel_q} != cfg_prev_q;
    fb        = lvbl_q & ~lvbl;
    trig_edge = trig_q & ~trig_prev_q;
    load      = fb & ~freeze & ~cfg_chg;

    peak_v = (sample_q > acc_q) ? sample_q : acc_q;
    cnt_v  = (acc_q == 8'hFF) ? 8'hFF : acc_q + {7'd0, trig_edge};
    or_v   = acc_q | sample_q;

    acc_run  = 8'd0;
    acc_fb   = 8'd0;
    load_val = sample_q;
    case (mode_q)
      MODE_LIVE: begin
        acc_run  = 8'd0;
        acc_fb   = 8'd0;
        load_val = sample_q;
      end
      MODE_PEAK: begin
        acc_run  = peak_v;
        acc_fb   = sample_q;
        load_val = peak_v;
      end
      MODE_COUNT: begin
        acc_run  = cnt_v;
        acc_fb   = {7'd0, trig_edge};
        load_val = cnt_v;
      end
      MODE_OR: begin
        acc_run  = or_v;
        acc_fb   = or_v;
        load_val = or_v;
      end
      default: begin
        acc_run  = 8'd0;
        acc_fb   = 8'd0;
        load_val = sample_q;
      end
    endcase

    // reconfiguration wins over both a coincident frame boundary and freeze
    if (cfg_chg) begin
      acc_d       = 8'd0;
      view_d      = 8'd0;
      trig_prev_d = 1'b0;
    end else begin
      acc_d       = load ? acc_fb : acc_run;
      view_d      = load ? load_val : view_q;
      trig_prev_d = trig_q;
    end
    upd_d = load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= 2'd0;
      mode_q      <= MODE_LIVE;
      cfg_prev_q  <= 4'd0;
      sample_q    <= 8'd0;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      lvbl_q      <= 1'b0;
      acc_q       <= 8'd0;
      view_q      <= 8'd0;
      upd_q       <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      cfg_prev_q  <= cfg_prev_d;
      sample_q    <= sample_d;
      trig_q      <= trig_d;
      trig_prev_q <= trig_prev_d;
      lvbl_q      <= lvbl_d;
      acc_q       <= acc_d;
      view_q      <= view_d;
      upd_q       <= upd_d;
    end
  end

  assign debug_view = view_q;
  assign view_upd   = upd_q;

endmodule

// File: tb/tb_jtframe_debug_probe.sv
// Bench for jtframe_debug_probe: each frame boundary that should load pushes the
// expected view; a negedge monitor pops one entry per view_upd pulse.
module tb_jtframe_debug_probe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] debug_bus;
  logic       lvbl;
  logic       freeze;
  logic [7:0] probe0, probe1, probe2, probe3;
  logic [3:0] trig;
  logic [7:0] debug_view;
  logic       view_upd;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  jtframe_debug_probe dut (
    .clk        (clk),
    .rst        (rst),
    .debug_bus  (debug_bus),
    .lvbl       (lvbl),
    .freeze     (freeze),
    .probe0     (probe0),
    .probe1     (probe1),
    .probe2     (probe2),
    .probe3     (probe3),
    .trig       (trig),
    .debug_view (debug_view),
    .view_upd   (view_upd)
  );

  always #5 clk = ~clk;

  // scoreboard: every view_upd must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && view_upd === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL upd_unexpected: view_upd=1 view=%h, required no pulse", debug_view);
      end else begin
        exp_v = exp_q.pop_front();
        if (debug_view !== exp_v)
          $display("FAIL upd_value: view=%h, required %h", debug_view, exp_v);
        else
          n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic frame_bound();
    lvbl = 1'b0;
    tick(1);
    lvbl = 1'b1;
    tick(1);
  endtask

  task automatic pulse(input int ch);
    trig[ch] = 1'b1;
    tick(1);
    trig[ch] = 1'b0;
    tick(1);
  endtask

  task automatic set_cfg(input logic [7:0] bus);
    debug_bus = bus;
    tick(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; debug_bus = 8'h00; lvbl = 1'b1; freeze = 1'b0; trig = 4'h0;
    probe0 = 8'h00; probe1 = 8'h00; probe2 = 8'h00; probe3 = 8'h00;
    tick(2);
    n_total++;
    if (debug_view !== 8'h00) $display("FAIL reset_view: view=%h, required 00", debug_view);
    else n_pass++;
    n_total++;
    if (view_upd !== 1'b0) $display("FAIL reset_upd: upd=%b, required 0", view_upd);
    else n_pass++;
    // lvbl low on the very first clk after release must not count as a boundary
    rst = 1'b0; lvbl = 1'b0;
    tick(1);
    n_total++;
    if (view_upd !== 1'b0) $display("FAIL reset_no_fb: upd=%b, required 0", view_upd);
    else n_pass++;
    lvbl = 1'b1;
    tick(3);
  endtask

  task automatic test_live();
    set_cfg(8'h02);
    probe2 = 8'h5A;
    tick(1);
    exp_q.push_back(8'h5A);
    frame_bound();
    probe2 = 8'h33;
    tick(3);
    n_total++;
    if (debug_view !== 8'h5A) $display("FAIL live_hold: view=%h, required 5A", debug_view);
    else n_pass++;
    // upper bus bits are ignored: no reconfiguration clear
    debug_bus = 8'hF2;
    tick(3);
    n_total++;
    if (debug_view !== 8'h5A) $display("FAIL live_upper_bits: view=%h, required 5A", debug_view);
    else n_pass++;
    exp_q.push_back(8'h33);
    frame_bound();
    tick(1);
  endtask

  task automatic test_peak();
    set_cfg(8'h04);
    n_total++;
    if (debug_view !== 8'h00) $display("FAIL peak_cfg_clear: view=%h, required 00", debug_view);
    else n_pass++;
    probe0 = 8'h03; tick(2);
    probe0 = 8'hC7; tick(2);
    probe0 = 8'h10; tick(2);
    exp_q.push_back(8'hC7);
    frame_bound();
    tick(3);
    exp_q.push_back(8'h10);
    frame_bound();
    tick(1);
  endtask

  task automatic test_event();
    set_cfg(8'h09);
    for (int i = 0; i < 300; i++) pulse(1);
    exp_q.push_back(8'hFF);
    frame_bound();
    for (int i = 0; i < 4; i++) pulse(1);
    // fifth edge lands on the same clk as the boundary
    exp_q.push_back(8'h05);
    trig[1] = 1'b1;
    tick(1);
    lvbl = 1'b0; trig[1] = 1'b0;
    tick(1);
    lvbl = 1'b1;
    tick(2);
    pulse(1);
    pulse(1);
    exp_q.push_back(8'h03);
    frame_bound();
    tick(1);
  endtask

  task automatic test_sticky();
    set_cfg(8'h0F);
    probe3 = 8'h01; tick(2);
    exp_q.push_back(8'h01);
    frame_bound();
    probe3 = 8'h80; tick(2);
    exp_q.push_back(8'h81);
    frame_bound();
    tick(1);
    debug_bus = 8'h03;
    tick(2);
    n_total++;
    if (debug_view !== 8'h00) $display("FAIL sticky_cfg_clear: view=%h, required 00", debug_view);
    else n_pass++;
    tick(2);
  endtask

  task automatic test_freeze();
    set_cfg(8'h09);
    pulse(1); pulse(1);
    exp_q.push_back(8'h02);
    frame_bound();
    freeze = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 3; i++) pulse(1);
      frame_bound();
    end
    n_total++;
    if (debug_view !== 8'h02) $display("FAIL freeze_hold: view=%h, required 02", debug_view);
    else n_pass++;
    freeze = 1'b0;
    tick(2);
    n_total++;
    if (debug_view !== 8'h02) $display("FAIL unfreeze_no_load: view=%h, required 02", debug_view);
    else n_pass++;
    for (int i = 0; i < 3; i++) pulse(1);
    exp_q.push_back(8'h09);
    frame_bound();
    tick(1);
  endtask

  task automatic test_reset_mid();
    set_cfg(8'h04);
    probe0 = 8'hFF;
    tick(3);
    rst = 1'b1;
    probe0 = 8'h20;
    tick(1);
    n_total++;
    if (debug_view !== 8'h00) $display("FAIL midrst_view: view=%h, required 00", debug_view);
    else n_pass++;
    rst = 1'b0;
    tick(4);
    exp_q.push_back(8'h20);
    frame_bound();
    tick(2);
  endtask

  initial begin
    test_reset();
    test_live();
    test_peak();
    test_event();
    test_sticky();
    test_freeze();
    test_reset_mid();
    tick(4);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL missing_upd: pending=%0d, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
